// File: rtl/gig_eth_rx_frame_buf_pkg.sv
// -----------------------------------------------------------------------------
// gig_eth_rx_frame_buf_pkg
// Shared definitions for the gigabit Ethernet RX client frame buffer:
//   - write-side FSM state encoding
//   - buffer entry format: {eop, data[7:0]}, 9 bits, eop at bit 8
//   - helper to pack a buffer entry
// -----------------------------------------------------------------------------
package gig_eth_rx_frame_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_WRITE       = 2'd1,
      ST_WAIT_STATUS = 2'd2,
      ST_DROP        = 2'd3
   } rx_state_e;

   localparam int DATA_W  = 8;
   localparam int ENTRY_W = 9;
   localparam int EOP_BIT = 8;

   // Pack one buffer entry from its end-of-packet flag and data byte.
   function automatic logic [ENTRY_W-1:0] make_entry(input logic eop,
                                                     input logic [DATA_W-1:0] data);
      return {eop, data};
   endfunction

endpackage

// File: rtl/gig_eth_rx_frame_ram.sv
// -----------------------------------------------------------------------------
// gig_eth_rx_frame_ram
// Simple dual-port RAM, 2^ADDR_W x ENTRY_W, one write port and one read port
// with a registered read. The read register only updates when rd_en_i is set,
// so the last fetched entry stays on rd_data_o while the reader stalls.
//
// Ports:
//   rx_clk     clock
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write entry {eop, data}
//   rd_en_i    read enable (captures mem[rd_addr_i] on the next edge)
//   rd_addr_i  read address
//   rd_data_o  registered read entry
// -----------------------------------------------------------------------------
import gig_eth_rx_frame_buf_pkg::*;

module gig_eth_rx_frame_ram #(
   parameter int ADDR_W = 12
) (
   input  logic               rx_clk,
   input  logic               wr_en_i,
   input  logic [ADDR_W-1:0]  wr_addr_i,
   input  logic [ENTRY_W-1:0] wr_data_i,
   input  logic               rd_en_i,
   input  logic [ADDR_W-1:0]  rd_addr_i,
   output logic [ENTRY_W-1:0] rd_data_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [ENTRY_W-1:0] mem_q [0:DEPTH-1];
   logic [ENTRY_W-1:0] rd_data_q;

   // Storage array write port.
   always_ff @(posedge rx_clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read port; holds its value when no read is requested.
   always_ff @(posedge rx_clk) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gig_eth_rx_frame_buf.sv
// -----------------------------------------------------------------------------
// gig_eth_rx_frame_buf
// Client-side receiver for the gigabit MAC RX client interface. Frame bytes are
// stored in a circular buffer; a frame becomes visible to the reader only once
// the MAC reports goodframe. Bad frames, frames whose status never arrives and
// frames that overflow the buffer are discarded by rewinding the write pointer
// to the last committed position. Everything runs in the rx_clk domain.
//
// Optional build macro: GIG_ETH_RX_FRAME_BUF_STATS_EN
//   defined   -> saturating stat_good/stat_bad/stat_drop counters
//   undefined -> no counter registers, stat_* outputs tied to zero
//
// Ports:
//   rx_clk            125 MHz GMII RX clock
//   reset             asynchronous, active-high reset
//   mac_rx_data       RX byte from the MAC
//   mac_rx_dvld       byte valid, contiguous for the frame body
//   mac_rx_goodframe  one-cycle good status pulse after dvld falls
//   mac_rx_badframe   one-cycle bad status pulse after dvld falls
//   out_data          frame byte to the reader
//   out_eop           last byte of the frame
//   out_valid         out_data/out_eop valid
//   out_ready         reader accepts when out_valid && out_ready
//   stat_good         committed frames
//   stat_bad          frames discarded on bad (or missing) status
//   stat_drop         frames discarded on overflow
// -----------------------------------------------------------------------------
import gig_eth_rx_frame_buf_pkg::*;

module gig_eth_rx_frame_buf #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic             rx_clk,
   input  logic             reset,
   input  logic [7:0]       mac_rx_data,
   input  logic             mac_rx_dvld,
   input  logic             mac_rx_goodframe,
   input  logic             mac_rx_badframe,
   output logic [7:0]       out_data,
   output logic             out_eop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] stat_good,
   output logic [CNT_W-1:0] stat_bad,
   output logic [CNT_W-1:0] stat_drop
);

   localparam int PTR_W = ADDR_W + 1;
   // Pointer difference that means every entry is occupied.
   localparam logic [PTR_W-1:0] FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};

   // ---------------------------------------------------------------------
   // Write-side state
   // ---------------------------------------------------------------------
   rx_state_e          state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
   logic [DATA_W-1:0]  pend_data_q, pend_data_d;
   logic               pend_vld_q, pend_vld_d;

   logic               full_s;
   logic               ram_we_s;
   logic [ENTRY_W-1:0] ram_wdata_s;
   logic               inc_good_s;
   logic               inc_bad_s;
   logic               inc_drop_s;

   // ---------------------------------------------------------------------
   // Read-side state
   // ---------------------------------------------------------------------
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               ram_vld_q, ram_vld_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_eop_q, out_eop_d;
   logic               out_valid_q, out_valid_d;

   logic               readable_s;
   logic               out_free_s;
   logic               ram_move_s;
   logic               rd_en_s;
   logic [ENTRY_W-1:0] ram_rdata_s;

   // Full is judged against the current read pointer; a read in this cycle
   // frees its entry for the next cycle only.
   assign full_s     = ((wr_ptr_q - rd_ptr_q) == FULL_DIFF);
   assign readable_s = (rd_ptr_q != commit_ptr_q);

   // Write FSM next-state, buffer write and statistics strobes.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      pend_data_d  = pend_data_q;
      pend_vld_d   = pend_vld_q;
      ram_we_s     = 1'b0;
      ram_wdata_s  = make_entry(1'b0, pend_data_q);
      inc_good_s   = 1'b0;
      inc_bad_s    = 1'b0;
      inc_drop_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Status pulses here belong to no stored frame and are ignored.
            if (mac_rx_dvld) begin
               pend_data_d = mac_rx_data;
               pend_vld_d  = 1'b1;
               state_d     = ST_WRITE;
            end else begin
               state_d     = ST_IDLE;
            end
         end

         ST_WRITE: begin
            if (pend_vld_q && full_s) begin
               // Pending byte (body or eop flush) has nowhere to go.
               wr_ptr_d   = commit_ptr_q;
               pend_vld_d = 1'b0;
               state_d    = ST_DROP;
            end else if (mac_rx_dvld) begin
               // A new byte pushes the held one into the buffer as body.
               ram_we_s    = pend_vld_q;
               ram_wdata_s = make_entry(1'b0, pend_data_q);
               wr_ptr_d    = wr_ptr_q + PTR_W'(pend_vld_q);
               pend_data_d = mac_rx_data;
               pend_vld_d  = 1'b1;
            end else begin
               // dvld fell: the held byte is the last of the frame.
               ram_we_s    = pend_vld_q;
               ram_wdata_s = make_entry(1'b1, pend_data_q);
               wr_ptr_d    = wr_ptr_q + PTR_W'(pend_vld_q);
               pend_vld_d  = 1'b0;
               state_d     = ST_WAIT_STATUS;
            end
         end

         ST_WAIT_STATUS: begin
            if (mac_rx_goodframe) begin
               commit_ptr_d = wr_ptr_q;
               inc_good_s   = 1'b1;
            end else if (mac_rx_badframe || mac_rx_dvld) begin
               // A new frame starting without status also condemns this one.
               wr_ptr_d  = commit_ptr_q;
               inc_bad_s = 1'b1;
            end else begin
               wr_ptr_d  = wr_ptr_q;
            end

            if (mac_rx_dvld) begin
               pend_data_d = mac_rx_data;
               pend_vld_d  = 1'b1;
               state_d     = ST_WRITE;
            end else if (mac_rx_goodframe || mac_rx_badframe) begin
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_WAIT_STATUS;
            end
         end

         ST_DROP: begin
            // Write pointer was rewound on entry; remaining bytes are ignored.
            if (mac_rx_goodframe || mac_rx_badframe) begin
               inc_drop_s = 1'b1;
               if (mac_rx_dvld) begin
                  pend_data_d = mac_rx_data;
                  pend_vld_d  = 1'b1;
                  state_d     = ST_WRITE;
               end else begin
                  state_d     = ST_IDLE;
               end
            end else begin
               state_d = ST_DROP;
            end
         end

         default: begin
            wr_ptr_d   = commit_ptr_q;
            pend_vld_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // Write-side registers.
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= {PTR_W{1'b0}};
         commit_ptr_q <= {PTR_W{1'b0}};
         pend_data_q  <= 8'h00;
         pend_vld_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         pend_data_q  <= pend_data_d;
         pend_vld_q   <= pend_vld_d;
      end
   end

   gig_eth_rx_frame_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .rx_clk    (rx_clk),
      .wr_en_i   (ram_we_s),
      .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
      .wr_data_i (ram_wdata_s),
      .rd_en_i   (rd_en_s),
      .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
      .rd_data_o (ram_rdata_s)
   );

   // Read pipeline: RAM output register feeding a one-entry output register.
   // The RAM register is refilled whenever it is empty or drains this cycle.
   always_comb begin
      out_free_s  = !out_valid_q || out_ready;
      ram_move_s  = ram_vld_q && out_free_s;
      rd_en_s     = readable_s && (!ram_vld_q || ram_move_s);
      rd_ptr_d    = rd_ptr_q;
      ram_vld_d   = ram_vld_q;
      out_data_d  = out_data_q;
      out_eop_d   = out_eop_q;
      out_valid_d = out_valid_q;

      if (rd_en_s) begin
         rd_ptr_d  = rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
         ram_vld_d = 1'b1;
      end else if (ram_move_s) begin
         ram_vld_d = 1'b0;
      end else begin
         ram_vld_d = ram_vld_q;
      end

      if (out_free_s) begin
         if (ram_vld_q) begin
            out_data_d  = ram_rdata_s[DATA_W-1:0];
            out_eop_d   = ram_rdata_s[EOP_BIT];
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Read-side registers.
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q    <= {PTR_W{1'b0}};
         ram_vld_q   <= 1'b0;
         out_data_q  <= 8'h00;
         out_eop_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         ram_vld_q   <= ram_vld_d;
         out_data_q  <= out_data_d;
         out_eop_q   <= out_eop_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_eop   = out_eop_q;
   assign out_valid = out_valid_q;

`ifdef GIG_ETH_RX_FRAME_BUF_STATS_EN
   logic [CNT_W-1:0] stat_good_q;
   logic [CNT_W-1:0] stat_bad_q;
   logic [CNT_W-1:0] stat_drop_q;

   // Increment by one unless already at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
      if (en && (cnt != {CNT_W{1'b1}})) begin
         return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         return cnt;
      end
   endfunction

   // Saturating frame statistics.
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         stat_good_q <= {CNT_W{1'b0}};
         stat_bad_q  <= {CNT_W{1'b0}};
         stat_drop_q <= {CNT_W{1'b0}};
      end else begin
         stat_good_q <= sat_inc(stat_good_q, inc_good_s);
         stat_bad_q  <= sat_inc(stat_bad_q, inc_bad_s);
         stat_drop_q <= sat_inc(stat_drop_q, inc_drop_s);
      end
   end

   assign stat_good = stat_good_q;
   assign stat_bad  = stat_bad_q;
   assign stat_drop = stat_drop_q;
`else
   logic stats_unused_s;

   assign stats_unused_s = inc_good_s ^ inc_bad_s ^ inc_drop_s;
   assign stat_good      = {CNT_W{1'b0}};
   assign stat_bad       = {CNT_W{1'b0}};
   assign stat_drop      = {CNT_W{1'b0}};
`endif

endmodule
